// File: rtl/mouse_master_sm.sv
// mouse_master_sm
//   PS/2 mouse bring-up and packet sequencer. After reset it waits a settle
//   delay, sends 0xFF (reset) and expects 0xFA, 0xAA, 0x00, then sends 0xF4
//   (enable streaming) and expects 0xFA. It then assembles 3-byte movement
//   packets and pulses SEND_INTERRUPT once per packet. A protocol error
//   restarts the whole bring-up.
//
//   Optional: define MOUSE_TIMEOUT_EN to add a response watchdog
//   (TIMEOUT_CYCLES) on the wait states.
//
// Ports
//   CLK             system clock
//   RESET           synchronous active-low reset
//   SEND_BYTE       one-cycle transmit request
//   BYTE_TO_SEND    command byte, held until the next command
//   BYTE_SENT       transmitter done pulse
//   READ_ENABLE     receiver enable
//   BYTE_READ       received byte
//   BYTE_ERROR_CODE receiver error, 0 = good
//   BYTE_READY      received byte valid pulse
//   MOUSE_STATUS/DX/DY  last complete packet
//   SEND_INTERRUPT  one-cycle new-packet pulse
//   INIT_DONE       high while streaming
//   MASTER_STATE    current state code (debug)
module mouse_master_sm #(
  parameter int STARTUP_CYCLES = 5_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    ST_STARTUP       = 4'd0,
    ST_TX_RESET      = 4'd1,
    ST_WAIT_TX_RESET = 4'd2,
    ST_WAIT_ACK1     = 4'd3,
    ST_WAIT_SELFTEST = 4'd4,
    ST_WAIT_ID       = 4'd5,
    ST_TX_ENABLE     = 4'd6,
    ST_WAIT_TX_EN    = 4'd7,
    ST_WAIT_ACK2     = 4'd8,
    ST_PKT_B1        = 4'd9,
    ST_PKT_B2        = 4'd10,
    ST_PKT_B3        = 4'd11,
    ST_EMIT          = 4'd12
  } state_e;

  // One shared counter serves both the settle delay and the watchdog; it is
  // cleared on every state change so each use starts from zero.
  localparam int MAXC = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] START_LAST = CW'(STARTUP_CYCLES - 1);
`ifdef MOUSE_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    hold_st_q, hold_st_d;
  logic [7:0]    hold_dx_q, hold_dx_d;
  logic [7:0]    hold_dy_q, hold_dy_d;
  logic [7:0]    status_q, dx_q, dy_q;
  logic          send_q, send_d;
  logic          rd_en_q, rd_en_d;
  logic          init_q, init_d;
  logic          irq_q, irq_d;
  logic          cnt_en;
  logic          byte_ok;
  logic          timeout;

  assign byte_ok = BYTE_READY && (BYTE_ERROR_CODE == 2'd0);

  // Counter runs in STARTUP and, with the watchdog, in the wait states.
  always_comb begin
    cnt_en  = (state_q == ST_STARTUP);
    timeout = 1'b0;
`ifdef MOUSE_TIMEOUT_EN
    if (state_q inside {ST_WAIT_TX_RESET, ST_WAIT_ACK1, ST_WAIT_SELFTEST,
                        ST_WAIT_ID, ST_WAIT_TX_EN, ST_WAIT_ACK2}) begin
      cnt_en  = 1'b1;
      timeout = (cnt_q == TO_LAST);
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    hold_st_d = hold_st_q;
    hold_dx_d = hold_dx_q;
    hold_dy_d = hold_dy_q;
    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == START_LAST) begin
          state_d   = ST_TX_RESET;
          tx_byte_d = 8'hFF;
        end
      end
      ST_TX_RESET:      state_d = ST_WAIT_TX_RESET;
      ST_WAIT_TX_RESET: if (BYTE_SENT) state_d = ST_WAIT_ACK1;
      ST_WAIT_ACK1: if (BYTE_READY)
        state_d = (byte_ok && BYTE_READ == 8'hFA) ? ST_WAIT_SELFTEST : ST_STARTUP;
      ST_WAIT_SELFTEST: if (BYTE_READY)
        state_d = (byte_ok && BYTE_READ == 8'hAA) ? ST_WAIT_ID : ST_STARTUP;
      ST_WAIT_ID: begin
        if (BYTE_READY) begin
          if (byte_ok && BYTE_READ == 8'h00) begin
            state_d   = ST_TX_ENABLE;
            tx_byte_d = 8'hF4;
          end else begin
            state_d = ST_STARTUP;
          end
        end
      end
      ST_TX_ENABLE:  state_d = ST_WAIT_TX_EN;
      ST_WAIT_TX_EN: if (BYTE_SENT) state_d = ST_WAIT_ACK2;
      ST_WAIT_ACK2: if (BYTE_READY)
        state_d = (byte_ok && BYTE_READ == 8'hFA) ? ST_PKT_B1 : ST_STARTUP;
      // Bit 3 of the status byte is always set; use it to resync on byte 1.
      ST_PKT_B1: begin
        if (byte_ok && BYTE_READ[3]) begin
          hold_st_d = BYTE_READ;
          state_d   = ST_PKT_B2;
        end
      end
      ST_PKT_B2: begin
        if (BYTE_READY) begin
          if (byte_ok) begin
            hold_dx_d = BYTE_READ;
            state_d   = ST_PKT_B3;
          end else begin
            state_d = ST_PKT_B1;
          end
        end
      end
      ST_PKT_B3: begin
        if (BYTE_READY) begin
          if (byte_ok) begin
            hold_dy_d = BYTE_READ;
            state_d   = ST_EMIT;
          end else begin
            state_d = ST_PKT_B1;
          end
        end
      end
      ST_EMIT: state_d = ST_PKT_B1;
      default: state_d = ST_STARTUP;
    endcase
    // A byte or BYTE_SENT arriving with the timeout wins over the timeout.
    if (timeout && state_d == state_q) state_d = ST_STARTUP;
  end

  always_comb begin
    cnt_d   = (cnt_en && state_d == state_q) ? cnt_q + 1'b1 : '0;
    send_d  = (state_d == ST_TX_RESET) || (state_d == ST_TX_ENABLE);
    rd_en_d = (state_d inside {ST_WAIT_ACK1, ST_WAIT_SELFTEST, ST_WAIT_ID,
                               ST_WAIT_ACK2, ST_PKT_B1, ST_PKT_B2, ST_PKT_B3, ST_EMIT});
    init_d  = (state_d inside {ST_PKT_B1, ST_PKT_B2, ST_PKT_B3, ST_EMIT});
    irq_d   = (state_d == ST_EMIT);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_STARTUP;
      cnt_q     <= '0;
      tx_byte_q <= 8'h00;
      hold_st_q <= 8'h00;
      hold_dx_q <= 8'h00;
      hold_dy_q <= 8'h00;
      status_q  <= 8'h00;
      dx_q      <= 8'h00;
      dy_q      <= 8'h00;
      send_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      init_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      hold_st_q <= hold_st_d;
      hold_dx_q <= hold_dx_d;
      hold_dy_q <= hold_dy_d;
      send_q    <= send_d;
      rd_en_q   <= rd_en_d;
      init_q    <= init_d;
      irq_q     <= irq_d;
      // Load from the _d holding values so byte 3 lands together with EMIT.
      if (state_d == ST_EMIT) begin
        status_q <= hold_st_d;
        dx_q     <= hold_dx_d;
        dy_q     <= hold_dy_d;
      end
    end
  end

  assign SEND_BYTE      = send_q;
  assign BYTE_TO_SEND   = tx_byte_q;
  assign READ_ENABLE    = rd_en_q;
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign SEND_INTERRUPT = irq_q;
  assign INIT_DONE      = init_q;
  assign MASTER_STATE   = state_q;

endmodule

// File: doc/mouse_master_sm.md
# mouse_master_sm

PS/2 mouse bring-up and packet sequencer, between the mouse transmitter/receiver pair and the user-side registers. After power-up it resets the mouse (0xFF), checks the acknowledge (0xFA), self-test pass (0xAA) and device ID (0x00), then enables streaming (0xF4) and checks that acknowledge. From then on it assembles 3-byte movement packets and raises a one-cycle interrupt per packet. Any protocol error restarts the whole bring-up sequence.

## Interface
- STARTUP_CYCLES, 5_000_000: settle delay after reset before the first command (50 ms at 100 MHz).
- TIMEOUT_CYCLES, 100_000_000: response watchdog limit in cycles; used only with MOUSE_TIMEOUT_EN.
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-low reset; RESET=0 at a CLK rising edge resets the block.
- SEND_BYTE  out  1  one-cycle request to the transmitter.
- BYTE_TO_SEND  out  8  command byte; stable from the SEND_BYTE cycle until BYTE_SENT.
- BYTE_SENT  in  1  transmitter pulse: the mouse has acknowledged the byte at line level.
- READ_ENABLE  out  1  enables the receiver.
- BYTE_READ  in  8  byte from the receiver.
- BYTE_ERROR_CODE  in  2  receiver error; 0 means the byte is good.
- BYTE_READY  in  1  one-cycle pulse: BYTE_READ and BYTE_ERROR_CODE are valid.
- MOUSE_STATUS  out  8  packet byte 1, registered.
- MOUSE_DX  out  8  packet byte 2, registered.
- MOUSE_DY  out  8  packet byte 3, registered.
- SEND_INTERRUPT  out  1  one-cycle pulse: a new packet is on the outputs.
- INIT_DONE  out  1  high while streaming.
- MASTER_STATE  out  4  current state encoding, for debug.

## Operation
- States and encoding: 0 STARTUP, 1 TX_RESET, 2 WAIT_TX_RESET, 3 WAIT_ACK1, 4 WAIT_SELFTEST, 5 WAIT_ID, 6 TX_ENABLE, 7 WAIT_TX_ENABLE, 8 WAIT_ACK2, 9 PKT_B1, 10 PKT_B2, 11 PKT_B3, 12 EMIT. Codes 13-15 go to STARTUP.
- STARTUP:
  - counts 0..STARTUP_CYCLES-1;
  - at the terminal count, clears the counter and goes to TX_RESET.
- TX_RESET / TX_ENABLE:
  - SEND_BYTE=1 for this single cycle;
  - BYTE_TO_SEND = 0xFF / 0xF4;
  - unconditional move to the matching WAIT_TX state.
- WAIT_TX_*: hold until BYTE_SENT, then go to WAIT_ACK1 / WAIT_ACK2.
- Response states (WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2):
  - on BYTE_READY with BYTE_ERROR_CODE=0 and BYTE_READ equal to the expected byte (0xFA, 0xAA, 0x00, 0xFA): advance;
  - on BYTE_READY with any other byte or error: go to STARTUP.
- READ_ENABLE=1 in states 3-5 and 8-12; 0 elsewhere.
- PKT_B1 (INIT_DONE=1 from here through EMIT):
  - accept a byte only if the error code is 0 and BYTE_READ[3]=1; latch it into the status holding register, go to PKT_B2;
  - a byte failing either check is dropped and the state stays PKT_B1 (resync, no restart).
- PKT_B2 / PKT_B3:
  - a good byte is latched into DX / DY holding and the state advances;
  - an errored byte returns to PKT_B1 and the partial packet is discarded.
- EMIT:
  - copy the holding registers to MOUSE_STATUS/DX/DY together;
  - SEND_INTERRUPT=1 for this cycle;
  - go to PKT_B1.
- Outputs MOUSE_* change only in EMIT.

## Timing
- Reset values:
  - state STARTUP, all counters 0;
  - SEND_BYTE=0, BYTE_TO_SEND=0x00, READ_ENABLE=0;
  - MOUSE_STATUS=MOUSE_DX=MOUSE_DY=0x00;
  - SEND_INTERRUPT=0, INIT_DONE=0, MASTER_STATE=0.
- All outputs are registered (Moore). They reflect the current state one cycle after the input condition that caused the transition.
- First SEND_BYTE appears STARTUP_CYCLES+1 cycles after RESET releases.
- Final BYTE_READY of a packet → SEND_INTERRUPT exactly 1 cycle later; the next byte is accepted in the cycle after EMIT.
- BYTE_READY pulses arriving in TX, WAIT_TX, STARTUP or EMIT states are ignored.
- Reset mid-operation (including during a transmit): the block returns to STARTUP on the next edge and SEND_BYTE is forced low.
- Restart to STARTUP clears INIT_DONE in the same transition and leaves the MOUSE_* values unchanged.

## Configuration
- MOUSE_TIMEOUT_EN defined:
  - a watchdog counts cycles in states 2-5, 7 and 8;
  - reaching TIMEOUT_CYCLES-1 goes to STARTUP;
  - the counter clears on every state change;
  - if BYTE_READY coincides with the timeout, the byte is processed and the timeout is ignored.
- MOUSE_TIMEOUT_EN undefined: no watchdog logic; those states wait indefinitely.

## Test plan
- Model mouse answers FA, AA, 00, then FA after F4 → exactly two SEND_BYTE pulses (0xFF, then 0xF4); INIT_DONE=1 one cycle after the final FA.
- Streaming, bytes 0x09, 0x05, 0xFB → one SEND_INTERRUPT; MOUSE_STATUS=0x09, MOUSE_DX=0x05, MOUSE_DY=0xFB.
- In PKT_B1 send 0x01, then 0x08, 0x10, 0x20 → 0x01 dropped; one packet 0x08/0x10/0x20.
- 0xFC received in WAIT_ACK1 → MASTER_STATE=0, INIT_DONE=0; bring-up repeats with a fresh 0xFF.
- RESET=0 for one cycle in the middle of WAIT_SELFTEST → all outputs return to reset values on the next edge.
- With MOUSE_TIMEOUT_EN and TIMEOUT_CYCLES=1000, no reply after 0xFF → return to STARTUP 1000 cycles after entering WAIT_TX_RESET.
